fifo_wptr_full: RTL and testbench
=================================

# fifo_wptr_full

Write-domain pointer and flag generator for the asynchronous FIFO. It sits directly upstream of `fifo_mem`, driving its `waddr` and `wfull` inputs. It holds the binary/Gray write pointer and synchronizes the read-domain Gray pointer into `wclk`. From these it produces full, almost-full, fill level and a sticky overflow flag.

## Interface
- `ADDR_WIDTH`, 4, memory address width; depth = 2**ADDR_WIDTH.
- `AFULL_THRESH`, 2**ADDR_WIDTH-2, `walmost_full` asserts when `wcount` >= this value.
- `SYNC_STAGES`, 2, flop depth of the `rptr` synchronizer; legal values are 2 and 3.
- `wclk` in 1: write-domain clock. This is the only clock in the block.
- `wrst` in 1: synchronous, active-high reset.
- `winc` in 1: write request from the producer.
- `wovf_clr` in 1: clears `woverflow`.
- `rptr` in ADDR_WIDTH+1: read-domain Gray pointer, asynchronous to `wclk`.
- `waddr` out ADDR_WIDTH: memory write address, to `fifo_mem`.
- `wptr` out ADDR_WIDTH+1: registered Gray write pointer, to the read domain.
- `wfull` out 1: FIFO full, to `fifo_mem` and the producer.
- `walmost_full` out 1: fill level >= `AFULL_THRESH`.
- `wcount` out ADDR_WIDTH+1: fill level as seen from the write side, 0..2**ADDR_WIDTH.
- `woverflow` out 1: sticky; a write was attempted while full.

## Operation
- Internal binary pointer `wbin` (ADDR_WIDTH+1 bits).
  - `wbin_next` = `wbin` + (`winc` && !`wfull`), modulo 2**(ADDR_WIDTH+1).
  - `wgray_next` = `wbin_next` ^ (`wbin_next` >> 1).
  - `wbin` and `wptr` register `wbin_next` and `wgray_next`.
- `waddr` = `wbin[ADDR_WIDTH-1:0]`, taken straight from the register with no added logic.
- `rptr` passes through `SYNC_STAGES` flops to give `wq2_rptr`. No other logic touches `rptr` before the first flop.
- Full condition: `wgray_next` == {~`wq2_rptr`[MSB:MSB-1], `wq2_rptr`[MSB-2:0]}. This value is registered into `wfull`.
- Fill level: `wcount` <= `wbin_next` - gray2bin(`wq2_rptr`), modulo 2**(ADDR_WIDTH+1).
- `walmost_full` <= (`wbin_next` - gray2bin(`wq2_rptr`)) >= `AFULL_THRESH`.
- Overflow:
  - `woverflow` sets on `winc` && `wfull`.
  - It clears on `wovf_clr`.
  - If set and clear occur in the same cycle, set wins.
- A write attempted while full is dropped: the pointer is held and no memory write occurs, because `fifo_mem` gates on `wfull`.
- Flags are pessimistic. `wfull`, `walmost_full` and `wcount` reflect a stale read pointer, so they over-report occupancy and never under-report it.
- Wrap-around: the pointer MSB toggles on each pass through the memory. Empty/full are distinguished only by the top two Gray bits.

## Timing
- Reset values, one edge after `wrst` is high: `wbin`=0, `wptr`=0, `waddr`=0, `wfull`=0, `walmost_full`=0, `wcount`=0, `woverflow`=0, synchronizer flops=0.
- Write acceptance: `winc` high with `wfull` low at edge N gives `waddr`/`wptr` advanced after edge N. Data is written at the old `waddr` on edge N.
- Full rises on the same edge that accepts the 2**ADDR_WIDTH-th outstanding write.
- Read progress: a change on `rptr` is visible in `wfull`/`wcount`/`walmost_full` after `SYNC_STAGES`+1 `wclk` edges.
- `wrst` mid-operation: all state clears on the next edge regardless of `winc`. The read domain must be reset concurrently; this is a system requirement and is not checked here.
- All outputs come directly from registers, except `waddr`, which is a slice of a register.

## Structure
- Shared package `fifo_pkg` holds:
  - `bin2gray` and `gray2bin` functions, parameterised by width.
  - The default `ADDR_WIDTH`.
- The read-side pointer block reuses the same package.
- One sub-module, `sync_2ff`: a width-parameterised N-stage synchronizer. It takes `wclk` and `wrst`, has depth `SYNC_STAGES`, and resets to 0.
- It is also instantiated by the read-pointer block.

## Test plan
All scenarios use ADDR_WIDTH=4, AFULL_THRESH=14, SYNC_STAGES=2.
- Reset: hold `wrst` for 1 cycle with `winc`=1 → all outputs are 0 on the next edge.
- Fill: `rptr`=0, 16 back-to-back `winc` → after the 16th edge `wfull`=1, `wptr`=5'b11000, `waddr`=0, `wcount`=16; `walmost_full` rises after the 14th edge.
- Overflow: while full, issue a 17th `winc` → `wptr` unchanged and `woverflow`=1. Then assert `wovf_clr` and `winc` together → `woverflow` stays 1. `wovf_clr` alone → 0.
- Drain: while full, set `rptr`=5'b00110 (binary 4) → `wfull`=0 and `wcount`=12 after 3 edges; `walmost_full` = 0.
- Wrap: 40 writes with `rptr` following `wptr` 2 cycles late → `waddr` wraps 15→0, `wptr` MSB toggles at writes 16 and 32, and `wfull` is never asserted.
- Mid-operation reset: assert `wrst` at `wcount`=9 → `wcount`, `wptr`, `wfull`, `woverflow` are 0 on the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and Gray/binary conversion helpers.
// The helpers operate on a zero-extended GRAY_MAX_W-bit value, so any pointer
// up to GRAY_MAX_W bits wide can be converted and then cast back to its width.
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int GRAY_MAX_W     = 32;

  // Binary to reflected Gray code.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code to binary: each binary bit is the XOR of all Gray bits
  // at and above it, i.e. the XOR of every right-shifted copy.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin = gray;
    for (int i = 1; i < GRAY_MAX_W; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// N-stage flop synchronizer for a Gray-coded bus crossing into wclk.
// The input goes straight into the first flop with no logic in front of it.
module sync_2ff #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift the asynchronous input through STAGES flops; clear all on reset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and flag generator for the asynchronous FIFO.
// Holds the binary/Gray write pointer, synchronizes the read Gray pointer into
// wclk and derives full, almost-full, fill level and sticky overflow. Flags
// use a stale read pointer, so they can only over-report occupancy.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int AFULL_THRESH = 2**ADDR_WIDTH - 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic                wovf_clr,
  input  logic [ADDR_WIDTH:0] rptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0] wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDR_WIDTH:0] wcount,
  output logic                woverflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] wbin_q,  wbin_d;
  logic [PTR_W-1:0] wptr_q,  wptr_d;
  logic [PTR_W-1:0] wcount_q, wcount_d;
  logic             wfull_q, wfull_d;
  logic             walmost_full_q, walmost_full_d;
  logic             woverflow_q, woverflow_d;

  logic [PTR_W-1:0] wq2_rptr_s;
  logic [PTR_W-1:0] rbin_s;
  logic [PTR_W-1:0] full_gray_s;
  logic             wr_ok_s;

  sync_2ff #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_sync_rptr (
    .wclk (wclk),
    .wrst (wrst),
    .d_i  (rptr),
    .q_o  (wq2_rptr_s)
  );

  // Next pointer, full/almost-full/fill-level and sticky overflow.
  always_comb begin
    wr_ok_s        = winc & ~wfull_q;
    wbin_d         = wbin_q + PTR_W'(wr_ok_s);
    wptr_d         = PTR_W'(bin2gray(GRAY_MAX_W'(wbin_d)));
    rbin_s         = PTR_W'(gray2bin(GRAY_MAX_W'(wq2_rptr_s)));
    // Full when the write pointer is one lap ahead: top two Gray bits
    // inverted, remaining bits equal.
    full_gray_s    = {~wq2_rptr_s[PTR_W-1:PTR_W-2], wq2_rptr_s[PTR_W-3:0]};
    wfull_d        = (wptr_d == full_gray_s);
    wcount_d       = wbin_d - rbin_s;
    walmost_full_d = (wcount_d >= PTR_W'(AFULL_THRESH));
    // A new overflow event takes priority over a clear in the same cycle.
    if (winc && wfull_q) begin
      woverflow_d = 1'b1;
    end else if (wovf_clr) begin
      woverflow_d = 1'b0;
    end else begin
      woverflow_d = woverflow_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wcount_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wcount_q       <= wcount_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
    end
  end

  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wcount       = wcount_q;
  assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full with an occupancy-based reference model
// and an expected-result queue popped one cycle after each stimulus step.
module tb_fifo_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst = 1'b0;
  logic       winc = 1'b0;
  logic       wovf_clr = 1'b0;
  logic [4:0] rptr = 5'd0;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wcount;
  logic       woverflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       full;
    logic       af;
    logic [4:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  logic [4:0] m_wbin = 5'd0;
  logic [4:0] m_s1 = 5'd0;
  logic [4:0] m_s2 = 5'd0;
  logic       m_full = 1'b0;
  logic       m_af = 1'b0;
  logic [4:0] m_cnt = 5'd0;
  logic       m_ovf = 1'b0;

  logic [4:0] hist[$];
  logic       ever_full;

  fifo_wptr_full #(
    .ADDR_WIDTH   (4),
    .AFULL_THRESH (14),
    .SYNC_STAGES  (2)
  ) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wovf_clr     (wovf_clr),
    .rptr         (rptr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, push the expectation,
  // then after the edge pop and compare against the DUT.
  task automatic step(input logic i_inc, input logic i_clr, input logic i_rst,
                      input logic [4:0] i_rptr);
    logic [4:0] nb;
    logic [4:0] occ;
    exp_t e;
    exp_t got;
    winc = i_inc; wovf_clr = i_clr; wrst = i_rst; rptr = i_rptr;
    if (i_rst) begin
      m_wbin = 5'd0; m_s1 = 5'd0; m_s2 = 5'd0;
      m_full = 1'b0; m_af = 1'b0; m_cnt = 5'd0; m_ovf = 1'b0;
    end else begin
      nb  = m_wbin + ((i_inc && !m_full) ? 5'd1 : 5'd0);
      occ = nb - g2b(m_s2);
      m_ovf  = (i_inc && m_full) ? 1'b1 : (i_clr ? 1'b0 : m_ovf);
      m_full = (occ == 5'd16);
      m_af   = (occ >= 5'd14);
      m_cnt  = occ;
      m_wbin = nb;
      m_s2   = m_s1;
      m_s1   = i_rptr;
    end
    e.waddr = m_wbin[3:0];
    e.wptr  = m_wbin ^ (m_wbin >> 1);
    e.full  = m_full;
    e.af    = m_af;
    e.cnt   = m_cnt;
    e.ovf   = m_ovf;
    exp_q.push_back(e);
    @(posedge wclk);
    #1;
    got = exp_q.pop_front();
    check("waddr", {4'd0, waddr}, {4'd0, got.waddr});
    check("wptr", {3'd0, wptr}, {3'd0, got.wptr});
    check("wfull", {7'd0, wfull}, {7'd0, got.full});
    check("walmost_full", {7'd0, walmost_full}, {7'd0, got.af});
    check("wcount", {3'd0, wcount}, {3'd0, got.cnt});
    check("woverflow", {7'd0, woverflow}, {7'd0, got.ovf});
  endtask

  initial begin
    // reset with winc high
    @(posedge wclk); #1;
    step(1'b1, 1'b0, 1'b1, 5'd0);
    check("rst_all_zero", {waddr, wfull, walmost_full, woverflow, 1'b0}, 8'd0);

    // fill 16 writes with rptr = 0
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 1'b0, 5'd0);
      if (k == 13) check("af_low_at13", {7'd0, walmost_full}, 8'd0);
      if (k == 14) check("af_high_at14", {7'd0, walmost_full}, 8'd1);
      if (k == 15) check("not_full_at15", {7'd0, wfull}, 8'd0);
    end
    check("fill_wfull", {7'd0, wfull}, 8'd1);
    check("fill_wptr", {3'd0, wptr}, 8'b0001_1000);
    check("fill_waddr", {4'd0, waddr}, 8'd0);
    check("fill_wcount", {3'd0, wcount}, 8'd16);

    // overflow
    step(1'b1, 1'b0, 1'b0, 5'd0);
    check("ovf_wptr_held", {3'd0, wptr}, 8'b0001_1000);
    check("ovf_set", {7'd0, woverflow}, 8'd1);
    step(1'b1, 1'b1, 1'b0, 5'd0);
    check("ovf_set_wins", {7'd0, woverflow}, 8'd1);
    step(1'b0, 1'b1, 1'b0, 5'd0);
    check("ovf_cleared", {7'd0, woverflow}, 8'd0);

    // drain: reader at binary 4
    step(1'b0, 1'b0, 1'b0, 5'b00110);
    step(1'b0, 1'b0, 1'b0, 5'b00110);
    check("drain_still_full_e2", {7'd0, wfull}, 8'd1);
    step(1'b0, 1'b0, 1'b0, 5'b00110);
    check("drain_wfull", {7'd0, wfull}, 8'd0);
    check("drain_wcount", {3'd0, wcount}, 8'd12);
    check("drain_af", {7'd0, walmost_full}, 8'd0);

    // wrap: 40 writes with reader trailing two cycles behind
    step(1'b0, 1'b0, 1'b1, 5'd0);
    hist.delete();
    ever_full = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      logic [4:0] rp;
      rp = (hist.size() >= 2) ? hist[hist.size()-2] : 5'd0;
      step(1'b1, 1'b0, 1'b0, rp);
      hist.push_back(m_wbin ^ (m_wbin >> 1));
      ever_full = ever_full | wfull;
      if (k == 15) begin
        check("wrap_waddr15", {4'd0, waddr}, 8'd15);
        check("wrap_msb15", {7'd0, wptr[4]}, 8'd0);
      end
      if (k == 16) begin
        check("wrap_waddr0", {4'd0, waddr}, 8'd0);
        check("wrap_msb16", {7'd0, wptr[4]}, 8'd1);
      end
      if (k == 31) check("wrap_msb31", {7'd0, wptr[4]}, 8'd1);
      if (k == 32) check("wrap_msb32", {7'd0, wptr[4]}, 8'd0);
    end
    check("wrap_never_full", {7'd0, ever_full}, 8'd0);

    // mid-operation reset at wcount = 9
    step(1'b0, 1'b0, 1'b1, 5'd0);
    for (int k = 1; k <= 9; k++) step(1'b1, 1'b0, 1'b0, 5'd0);
    check("mid_wcount9", {3'd0, wcount}, 8'd9);
    step(1'b1, 1'b0, 1'b1, 5'd0);
    check("mid_rst_wcount", {3'd0, wcount}, 8'd0);
    check("mid_rst_wptr", {3'd0, wptr}, 8'd0);
    check("mid_rst_flags", {6'd0, wfull, woverflow}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
